// File: rtl/seq_sub32.sv
// seq_sub32 -- sequential 32-bit subtractor: diff = a - b - bin (mod 2^32).
//
// The operands are taken on an input handshake. The result is then computed
// CHUNK bits per cycle, least significant slice first, with a ripple borrow.
// The result is held under a valid/ready output handshake.
//
// Parameter:
//   CHUNK      bits processed per BUSY cycle (1, 2, 4, 8, 16 or 32)
// Optional feature:
//   SUB32_OVF_EN  when defined, adds the ovf output (signed overflow flag)
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   a, b, bin  minuend, subtrahend, borrow-in (sampled on accept only)
//   in_valid   upstream operands valid
//   in_ready   block is idle and can accept operands
//   diff, bout result and borrow-out (bout=1 iff a < b + bin, unsigned)
//   out_valid  diff/bout valid
//   out_ready  downstream takes the result
//   ovf        signed overflow (only with SUB32_OVF_EN)
module seq_sub32 #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] diff,
  output logic        bout,
  output logic        out_valid,
  input  logic        out_ready
`ifdef SUB32_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int NSLICE = 32 / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;

  // Operand shift registers: the current slice always sits in the low CHUNK bits.
  logic [31:0]     a_r;
  logic [31:0]     b_r;
  logic            borrow_r;
  logic [31:0]     work_r;
  logic [CW-1:0]   cnt_r;

  logic [CHUNK:0]  slice_s;
  logic [31:0]     slice_ext_s;
  logic [31:0]     work_next_s;
  logic            last_s;

`ifdef SUB32_OVF_EN
  // Operand sign bits are kept because a_r/b_r are shifted away during BUSY.
  logic            sign_a_r;
  logic            sign_b_r;
`endif

  // One CHUNK-bit slice of a - b - borrow. The top bit of the (CHUNK+1)-bit
  // difference is the borrow into the next slice.
  function automatic logic [CHUNK:0] sub_slice(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             bi
  );
    logic [CHUNK:0] t;
    t = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bi};
    return t;
  endfunction

  // Slice arithmetic; finished slices enter the work register from the top.
  always_comb begin
    slice_s     = sub_slice(a_r[CHUNK-1:0], b_r[CHUNK-1:0], borrow_r);
    slice_ext_s = 32'(slice_s[CHUNK-1:0]);
    work_next_s = (work_r >> CHUNK) | (slice_ext_s << (32 - CHUNK));
    last_s      = (cnt_r == CNT_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: handshake flags decoded straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, per-slice update, result commit on entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      borrow_r <= 1'b0;
      work_r   <= 32'd0;
      cnt_r    <= '0;
      diff     <= 32'd0;
      bout     <= 1'b0;
`ifdef SUB32_OVF_EN
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bin;
            work_r   <= 32'd0;
            cnt_r    <= '0;
`ifdef SUB32_OVF_EN
            sign_a_r <= a[31];
            sign_b_r <= b[31];
`endif
          end
        end
        BUSY: begin
          a_r      <= a_r >> CHUNK;
          b_r      <= b_r >> CHUNK;
          borrow_r <= slice_s[CHUNK];
          work_r   <= work_next_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (last_s) begin
            diff <= work_next_s;
            bout <= slice_s[CHUNK];
`ifdef SUB32_OVF_EN
            ovf  <= (sign_a_r != sign_b_r) && (work_next_s[31] != sign_a_r);
`endif
          end
        end
        default: begin
          // DONE: everything holds until the result is taken.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sub32.sv
// Self-checking bench for seq_sub32. Three instances (CHUNK = 8, 1, 32) share
// one stimulus stream. Results come from a plain-arithmetic reference model.
// Latency is measured independently for each instance.
module tb_seq_sub32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        bin, in_valid, out_ready;

  logic        in_ready8, out_valid8, bout8;
  logic [31:0] diff8;
  logic        in_ready1, out_valid1, bout1;
  logic [31:0] diff1;
  logic        in_ready32, out_valid32, bout32;
  logic [31:0] diff32;
`ifdef SUB32_OVF_EN
  logic        ovf8, ovf1, ovf32;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_sub32 #(.CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready8), .diff(diff8), .bout(bout8), .out_valid(out_valid8),
    .out_ready(out_ready)
`ifdef SUB32_OVF_EN
    , .ovf(ovf8)
`endif
  );

  seq_sub32 #(.CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready1), .diff(diff1), .bout(bout1), .out_valid(out_valid1),
    .out_ready(out_ready)
`ifdef SUB32_OVF_EN
    , .ovf(ovf1)
`endif
  );

  seq_sub32 #(.CHUNK(32)) dut32 (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready32), .diff(diff32), .bout(bout32), .out_valid(out_valid32),
    .out_ready(out_ready)
`ifdef SUB32_OVF_EN
    , .ovf(ovf32)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 33-bit unsigned difference, top bit is the borrow.
  function automatic logic [32:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {32'd0, bi};
  endfunction

`ifdef SUB32_OVF_EN
  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y, input logic bi);
    logic [32:0] r;
    r = ref_sub(x, y, bi);
    return (x[31] != y[31]) && (r[31] != x[31]);
  endfunction
`endif

  // Runs one operation on all three instances. It checks latency, the held
  // outputs during BUSY and the final results. With rel=1 it also releases
  // the result and checks the return to IDLE.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin, input logic rel);
    logic [32:0] exp;
    logic [31:0] prev8;
    int lat8, lat1, lat32;
    exp   = ref_sub(ta, tb_v, tbin);
    prev8 = diff8;
    lat8 = 0; lat1 = 0; lat32 = 0;
    check_eq("ready_before", {61'd0, in_ready8, in_ready1, in_ready32}, 64'd7);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (lat8 != 0 && lat1 != 0 && lat32 != 0) break;
      @(posedge clk); #1;
      if (lat8 == 0 && out_valid8)   lat8 = c;
      if (lat1 == 0 && out_valid1)   lat1 = c;
      if (lat32 == 0 && out_valid32) lat32 = c;
      if (lat8 == 0) check_eq("busy_hold8", 64'(diff8), 64'(prev8));
    end
    check_eq("latency8", 64'(lat8), 64'd4);
    check_eq("latency1", 64'(lat1), 64'd32);
    check_eq("latency32", 64'(lat32), 64'd1);
    check_eq("diff8", 64'(diff8), 64'(exp[31:0]));
    check_eq("diff1", 64'(diff1), 64'(exp[31:0]));
    check_eq("diff32", 64'(diff32), 64'(exp[31:0]));
    check_eq("bout", {61'd0, bout8, bout1, bout32}, exp[32] ? 64'd7 : 64'd0);
`ifdef SUB32_OVF_EN
    check_eq("ovf", {61'd0, ovf8, ovf1, ovf32}, ref_ovf(ta, tb_v, tbin) ? 64'd7 : 64'd0);
`endif
    if (rel) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("back_idle", {58'd0, in_ready8, in_ready1, in_ready32,
                             out_valid8, out_valid1, out_valid32}, 64'h38);
      @(posedge clk); #1;
      check_eq("idle_hold8", 64'(diff8), 64'(exp[31:0]));
    end
  endtask

  initial begin
    rst = 1'b1; a = 32'd0; b = 32'd0; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    check_eq("rst_ready", {61'd0, in_ready8, in_ready1, in_ready32}, 64'd7);
    check_eq("rst_valid", {61'd0, out_valid8, out_valid1, out_valid32}, 64'd0);
    check_eq("rst_diff8", 64'(diff8), 64'd0);
    check_eq("rst_bout8", 64'(bout8), 64'd0);
`ifdef SUB32_OVF_EN
    check_eq("rst_ovf8", 64'(ovf8), 64'd0);
`endif

    // Directed corner cases.
    run_op(32'd35000, 32'd35000, 1'b0, 1'b1);
    run_op(32'd0, 32'd1, 1'b0, 1'b1);
    run_op(32'd100, 32'd50, 1'b1, 1'b1);
    run_op(32'd0, 32'd0, 1'b1, 1'b1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    run_op(32'd5, 32'd3, 1'b0, 1'b1);

    // The result must stay put while out_ready=0, whatever in_valid and a do.
    run_op(32'd7, 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i & 1);
      a = $urandom;
      @(posedge clk); #1;
      check_eq("hold_diff", 64'(diff8), 64'd4);
      check_eq("hold_flags", {62'd0, in_ready8, out_valid8}, 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("release_idle", {62'd0, in_ready8, out_valid8}, 64'd2);
    @(posedge clk); #1;
    check_eq("no_second_accept", {62'd0, in_ready8, out_valid8}, 64'd2);

    // A reset in the second BUSY cycle abandons the operation.
    a = 32'd100; b = 32'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_ready", 64'(in_ready8), 64'd1);
    check_eq("abort_diff", 64'(diff8), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("abort_no_valid", {61'd0, out_valid8, out_valid1, out_valid32}, 64'd0);
    end
    run_op(32'd12345, 32'd345, 1'b0, 1'b1);

    // Random operands.
    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
